// File: rtl/cv32e40x_xif_result_buffer_pkg.sv
// Shared types for the eXtension-interface result buffer: entry record, width limits
// and a popcount helper.
package cv32e40x_pkg;

    localparam int unsigned XIF_RBUF_MAX_DEPTH = 16;
    localparam int unsigned XIF_RBUF_ID_WIDTH  = 4;
    localparam int unsigned XIF_RBUF_RFW_WIDTH = 32;

    typedef logic [XIF_RBUF_ID_WIDTH-1:0]  xif_rbuf_id_t;
    typedef logic [XIF_RBUF_RFW_WIDTH-1:0] xif_rbuf_data_t;
    typedef logic [XIF_RBUF_MAX_DEPTH-1:0] xif_rbuf_vec_t;

    typedef struct packed {
        logic           valid;
        xif_rbuf_id_t   id;
        xif_rbuf_data_t data;
        logic [4:0]     rd;
        logic           we;
        logic           exc;
        logic [5:0]     exccode;
    } xif_rbuf_entry_t;

    function automatic logic [4:0] xif_rbuf_popcount(input xif_rbuf_vec_t vec);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < int'(XIF_RBUF_MAX_DEPTH); i++) begin
            cnt = cnt + {4'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cv32e40x_xif_result_buffer_ff_one.sv
// cv32e40x_ff_one: index of the lowest set bit of in_i, plus an all-zero flag.
module cv32e40x_ff_one #(
    parameter int unsigned LEN = 4
) (
    input  logic [LEN-1:0]                           in_i,
    output logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] first_one_o,
    output logic                                     no_ones_o
);

    localparam int unsigned POSW = (LEN > 1) ? $clog2(LEN) : 1;

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        first_one_o = '0;
        for (int i = int'(LEN) - 1; i >= 0; i--) begin
            first_one_o = in_i[i] ? POSW'(i) : first_one_o;
        end
        no_ones_o = ~|in_i;
    end

endmodule

// File: rtl/cv32e40x_xif_result_buffer.sv
// ID-tagged store for coprocessor results awaiting their instruction in WB.
// Optional same-cycle forwarding: define CV32E40X_XIF_RESULT_BYPASS_EN.
module cv32e40x_xif_result_buffer
    import cv32e40x_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFW_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          result_valid_i,
    output logic                          result_ready_o,
    input  logic [X_ID_WIDTH-1:0]         result_id_i,
    input  logic [X_RFW_WIDTH-1:0]        result_data_i,
    input  logic [4:0]                    result_rd_i,
    input  logic                          result_we_i,
    input  logic                          result_exc_i,
    input  logic [5:0]                    result_exccode_i,
    input  logic [(2**X_ID_WIDTH)-1:0]    id_live_i,
    input  logic                          flush_i,
    input  logic                          wb_query_valid_i,
    input  logic [X_ID_WIDTH-1:0]         wb_query_id_i,
    input  logic                          wb_consume_i,
    output logic                          wb_hit_o,
    output logic [X_RFW_WIDTH-1:0]        wb_data_o,
    output logic [4:0]                    wb_rd_o,
    output logic                          wb_we_o,
    output logic                          wb_exc_o,
    output logic [5:0]                    wb_exccode_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          full_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    xif_rbuf_entry_t r_entry [DEPTH];
    xif_rbuf_entry_t w_entry_nxt [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [DEPTH-1:0] w_live;
    logic [IW-1:0]    w_free_idx;
    logic [IW-1:0]    w_match_idx;
    logic [IW-1:0]    w_dup_idx;
    logic [IW-1:0]    w_store_idx;
    logic             w_no_free;
    logic             w_match;
    logic             w_dup;
    logic             w_accept;
    logic             w_store;
    logic             w_bypass;
    logic             w_consume_buf;

    assign full_o         = (r_count == CW'(DEPTH));
    assign result_ready_o = ~full_o;
    assign count_o        = r_count;
    assign w_accept       = result_valid_i & result_ready_o;

    cv32e40x_ff_one #(
        .LEN (DEPTH)
    ) u_free_slot (
        .in_i        (~w_valid),
        .first_one_o (w_free_idx),
        .no_ones_o   (w_no_free)
    );

    // Per-entry status plus lowest-index id matches for the WB query and the incoming result
    always_comb begin
        w_valid     = '0;
        w_live      = '0;
        w_match     = 1'b0;
        w_match_idx = '0;
        w_dup       = 1'b0;
        w_dup_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            w_valid[i]  = r_entry[i].valid;
            w_live[i]   = id_live_i[r_entry[i].id[X_ID_WIDTH-1:0]];
            w_match_idx = (r_entry[i].valid && r_entry[i].id == xif_rbuf_id_t'(wb_query_id_i))
                          ? IW'(i) : w_match_idx;
            w_match     = w_match | (r_entry[i].valid && r_entry[i].id == xif_rbuf_id_t'(wb_query_id_i));
            w_dup_idx   = (r_entry[i].valid && r_entry[i].id == xif_rbuf_id_t'(result_id_i))
                          ? IW'(i) : w_dup_idx;
            w_dup       = w_dup | (r_entry[i].valid && r_entry[i].id == xif_rbuf_id_t'(result_id_i));
        end
    end

    // WB lookup; a forwarded result outranks anything already buffered
    always_comb begin
        w_bypass     = 1'b0;
        wb_hit_o     = 1'b0;
        wb_data_o    = '0;
        wb_rd_o      = 5'd0;
        wb_we_o      = 1'b0;
        wb_exc_o     = 1'b0;
        wb_exccode_o = 6'd0;
`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
        w_bypass = w_accept && id_live_i[result_id_i] && wb_query_valid_i &&
                   (result_id_i == wb_query_id_i);
`else
        w_bypass = 1'b0;
`endif
        if (w_bypass) begin
            wb_hit_o     = 1'b1;
            wb_data_o    = result_data_i;
            wb_rd_o      = result_rd_i;
            wb_we_o      = result_we_i;
            wb_exc_o     = result_exc_i;
            wb_exccode_o = result_exccode_i;
        end else if (wb_query_valid_i && w_match) begin
            wb_hit_o     = 1'b1;
            wb_data_o    = r_entry[w_match_idx].data[X_RFW_WIDTH-1:0];
            wb_rd_o      = r_entry[w_match_idx].rd;
            wb_we_o      = r_entry[w_match_idx].we;
            wb_exc_o     = r_entry[w_match_idx].exc;
            wb_exccode_o = r_entry[w_match_idx].exccode;
        end else begin
            wb_hit_o     = 1'b0;
        end
    end

    // Next entry contents: flush beats everything, a store beats scrub/consume on its slot
    always_comb begin
        w_consume_buf = wb_consume_i && wb_query_valid_i && w_match && !w_bypass;
        w_store       = w_accept && id_live_i[result_id_i] && !flush_i &&
                        !(w_bypass && wb_consume_i) && (w_dup || !w_no_free);
        w_store_idx   = w_dup ? w_dup_idx : w_free_idx;
        w_valid_nxt   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_entry_nxt[i] = r_entry[i];
            if (flush_i) begin
                w_entry_nxt[i].valid = 1'b0;
            end else if (w_store && (w_store_idx == IW'(i))) begin
                w_entry_nxt[i].valid   = 1'b1;
                w_entry_nxt[i].id      = xif_rbuf_id_t'(result_id_i);
                w_entry_nxt[i].data    = xif_rbuf_data_t'(result_data_i);
                w_entry_nxt[i].rd      = result_rd_i;
                w_entry_nxt[i].we      = result_we_i;
                w_entry_nxt[i].exc     = result_exc_i;
                w_entry_nxt[i].exccode = result_exccode_i;
            end else if (!w_live[i] || (w_consume_buf && (w_match_idx == IW'(i)))) begin
                w_entry_nxt[i].valid = 1'b0;
            end else begin
                w_entry_nxt[i].valid = r_entry[i].valid;
            end
            w_valid_nxt[i] = w_entry_nxt[i].valid;
        end
    end

    // Entry storage and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_entry[i] <= w_entry_nxt[i];
            end
            r_count <= CW'(xif_rbuf_popcount(xif_rbuf_vec_t'(w_valid_nxt)));
        end
    end

endmodule
